// File: rtl/upe_seq_pkg.sv
// Shared definitions for the sequential uncertainty-propagation engine:
// FSM state encoding, datapath widths and the sign/magnitude helper.
package upe_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_TXY  = 3'd2,
        S_TY   = 3'd3,
        S_DONE = 3'd4
    } upe_state_e;

    localparam int OPND_W   = 16;
    localparam int PROD_W   = 48;
    localparam int RESULT_W = 64;

    // -32768 maps to 16'h8000, which is the correct unsigned magnitude.
    function automatic logic [OPND_W-1:0] mag16(input logic [OPND_W-1:0] v);
        return v[OPND_W-1] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/upe_triplemul16uuu.sv
// Combinational 16x16x16 unsigned triple multiplier with a full 48-bit product.
module upe_triplemul16uuu
    import upe_seq_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OPND_W-1:0] c,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] c_ext;

    assign a_ext = {{(PROD_W-OPND_W){1'b0}}, a};
    assign b_ext = {{(PROD_W-OPND_W){1'b0}}, b};
    assign c_ext = {{(PROD_W-OPND_W){1'b0}}, c};
    assign p     = a_ext * b_ext * c_ext;

endmodule

// File: rtl/upe_seq.sv
// Sequential uncertainty-propagation engine: one shared triple multiplier walks
// the x, cross and y terms of var_z over three cycles into a signed accumulator.
module upe_seq
    import upe_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         var_x,
    input  logic [15:0]         var_y,
    input  logic [15:0]         covar_xy,
    input  logic [15:0]         dfdx,
    input  logic [15:0]         dfdy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         var_z,
    output logic                busy
);

    upe_state_e          state_q, state_d;
    logic [OPND_W-1:0]   var_x_q, var_x_d;
    logic [OPND_W-1:0]   var_y_q, var_y_d;
    logic [OPND_W-1:0]   mag_xy_q, mag_xy_d;
    logic [OPND_W-1:0]   mag_dx_q, mag_dx_d;
    logic [OPND_W-1:0]   mag_dy_q, mag_dy_d;
    logic                sign_xy_q, sign_xy_d;
    logic [RESULT_W-1:0] acc_q, acc_d;

    logic [OPND_W-1:0]   mul_a, mul_b, mul_c;
    logic [PROD_W-1:0]   mul_p;
    logic [RESULT_W-1:0] prod_ext;
    logic [RESULT_W-1:0] prod_x2;

    upe_triplemul16uuu u_mul (
        .a (mul_a),
        .b (mul_b),
        .c (mul_c),
        .p (mul_p)
    );

    assign prod_ext = {{(RESULT_W-PROD_W){1'b0}}, mul_p};
    assign prod_x2  = {prod_ext[RESULT_W-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        var_x_d   = var_x_q;
        var_y_d   = var_y_q;
        mag_xy_d  = mag_xy_q;
        mag_dx_d  = mag_dx_q;
        mag_dy_d  = mag_dy_q;
        sign_xy_d = sign_xy_q;
        acc_d     = acc_q;
        // Operands stay at zero outside the term states so the multiplier is quiet.
        mul_a     = '0;
        mul_b     = '0;
        mul_c     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    var_x_d   = var_x;
                    var_y_d   = var_y;
                    mag_xy_d  = mag16(covar_xy);
                    mag_dx_d  = mag16(dfdx);
                    mag_dy_d  = mag16(dfdy);
                    sign_xy_d = covar_xy[15] ^ dfdx[15] ^ dfdy[15];
                    acc_d     = '0;
                    state_d   = S_TX;
                end
            end
            S_TX: begin
                mul_a   = var_x_q;
                mul_b   = mag_dx_q;
                mul_c   = mag_dx_q;
                acc_d   = prod_ext;
                state_d = S_TXY;
            end
            S_TXY: begin
                mul_a   = mag_xy_q;
                mul_b   = mag_dx_q;
                mul_c   = mag_dy_q;
                acc_d   = sign_xy_q ? (acc_q - prod_x2) : (acc_q + prod_x2);
                state_d = S_TY;
            end
            S_TY: begin
                mul_a   = var_y_q;
                mul_b   = mag_dy_q;
                mul_c   = mag_dy_q;
                acc_d   = acc_q + prod_ext;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            var_x_q   <= '0;
            var_y_q   <= '0;
            mag_xy_q  <= '0;
            mag_dx_q  <= '0;
            mag_dy_q  <= '0;
            sign_xy_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            var_x_q   <= var_x_d;
            var_y_q   <= var_y_d;
            mag_xy_q  <= mag_xy_d;
            mag_dx_q  <= mag_dx_d;
            mag_dy_q  <= mag_dy_d;
            sign_xy_q <= sign_xy_d;
            acc_q     <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign var_z     = acc_q;

endmodule

// File: tb/tb_upe_seq.sv
// Self-checking bench for upe_seq: directed corner cases plus randomized
// operand sets compared against a signed-arithmetic reference model.
module tb_upe_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] var_x, var_y, covar_xy, dfdx, dfdy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] var_z;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    upe_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .var_x     (var_x),
        .var_y     (var_y),
        .covar_xy  (covar_xy),
        .dfdx      (dfdx),
        .dfdy      (dfdy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .var_z     (var_z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the textbook propagation formula in signed 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [15:0] vx, input logic [15:0] vy,
                                          input logic [15:0] cxy, input logic [15:0] dx,
                                          input logic [15:0] dy);
        longint lvx, lvy, lcxy, ldx, ldy;
        lvx  = longint'(vx);
        lvy  = longint'(vy);
        lcxy = longint'($signed(cxy));
        ldx  = longint'($signed(dx));
        ldy  = longint'($signed(dy));
        return 64'(lvx * ldx * ldx + 2 * lcxy * ldx * ldy + lvy * ldy * ldy);
    endfunction

    // Drives one operand set at a negedge, waits for out_valid, optionally
    // holds off the consumer, then consumes the result. Performs no checks.
    task automatic do_op(input logic [15:0] vx, input logic [15:0] vy,
                         input logic [15:0] cxy, input logic [15:0] dx,
                         input logic [15:0] dy, input int hold,
                         output logic [63:0] z, output int lat, output bit timeout);
        var_x = vx; var_y = vy; covar_xy = cxy; dfdx = dx; dfdy = dy;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        timeout = !out_valid;
        z = var_z;
        for (int i = 0; i < hold; i++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        var_x = '0; var_y = '0; covar_xy = '0; dfdx = '0; dfdy = '0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || var_z !== 64'd0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b var_z=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, var_z);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_term();
        logic [63:0] z; int lat; bit to;
        do_op(16'd4, 16'd0, 16'd0, 16'd3, 16'd0, 0, z, lat, to);
        checks++;
        if (to || lat !== 3) begin
            failures++;
            $display("FAIL single_latency: got %0d timeout=%0d, want 3", lat, to);
        end
        checks++;
        if (z !== 64'd36) begin
            failures++;
            $display("FAIL single_value: got %h, want %h", z, 64'd36);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_return_idle: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_neg_cross();
        logic [63:0] z; int lat; bit to;
        do_op(16'd0, 16'd0, 16'd2, 16'hFFFF, 16'd5, 0, z, lat, to);
        checks++;
        if (to || z !== 64'hFFFF_FFFF_FFFF_FFEC) begin
            failures++;
            $display("FAIL neg_cross: got %h timeout=%0d, want FFFFFFFFFFFFFFEC", z, to);
        end
    endtask

    task automatic test_extremes();
        logic [63:0] z; int lat; bit to;
        do_op(16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000, 0, z, lat, to);
        checks++;
        if (to || z !== 64'h0000_BFFF_0000_0000) begin
            failures++;
            $display("FAIL extremes: got %h timeout=%0d, want 0000BFFF00000000", z, to);
        end
        do_op(16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 0, z, lat, to);
        checks++;
        if (to || z !== model(16'h0, 16'h0, 16'h8000, 16'h8000, 16'h7FFF)) begin
            failures++;
            $display("FAIL extremes_cross: got %h, want %h", z,
                     model(16'h0, 16'h0, 16'h8000, 16'h8000, 16'h7FFF));
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] z0;
        int lat;
        var_x = 16'd7; var_y = 16'd9; covar_xy = 16'hFFFD; dfdx = 16'd11; dfdy = 16'hFFF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL bp_reach_done: out_valid=%b after %0d cycles, want 1", out_valid, lat);
        end
        z0 = var_z;
        checks++;
        if (z0 !== model(16'd7, 16'd9, 16'hFFFD, 16'd11, 16'hFFF0)) begin
            failures++;
            $display("FAIL bp_value: got %h, want %h", z0, model(16'd7, 16'd9, 16'hFFFD, 16'd11, 16'hFFF0));
        end
        var_x = 16'd1; var_y = 16'd1; covar_xy = 16'd1; dfdx = 16'd1; dfdy = 16'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || var_z !== z0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: out_valid=%b var_z=%h in_ready=%b busy=%b, want 1 %h 0 1",
                         i, out_valid, var_z, in_ready, busy, z0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || var_z !== z0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b var_z=%h, want 1 0 %h",
                     in_ready, out_valid, var_z, z0);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] z; int lat; bit to;
        var_x = 16'd1000; var_y = 16'd3; covar_xy = 16'd50; dfdx = 16'd20; dfdy = 16'd30;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || var_z !== 64'd400000) begin
            failures++;
            $display("FAIL rstmid_in_txy: busy=%b var_z=%h, want 1 %h", busy, var_z, 64'd400000);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || var_z !== 64'd0) begin
            failures++;
            $display("FAIL rstmid_async: in_ready=%b out_valid=%b busy=%b var_z=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, var_z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_emit: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        do_op(16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 0, z, lat, to);
        checks++;
        if (to || z !== 64'd1) begin
            failures++;
            $display("FAIL rstmid_next_op: got %h timeout=%0d, want 1", z, to);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [5];
        logic [15:0] b [5];
        logic [63:0] res [2];
        int acc_cyc [2];
        int n_acc = 0;
        int n_res = 0;
        a = '{16'd123, 16'd45, 16'hFF00, 16'd300, 16'hFFF9};
        b = '{16'd9, 16'd800, 16'd77, 16'hFFFE, 16'd5};
        var_x = a[0]; var_y = a[1]; covar_xy = a[2]; dfdx = a[3]; dfdy = a[4];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && n_res < 2; k++) begin
            if (in_ready && in_valid && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
            if (out_valid) begin res[n_res] = var_z; n_res++; end
            @(negedge clk);
            if (n_acc == 1) begin
                var_x = b[0]; var_y = b[1]; covar_xy = b[2]; dfdx = b[3]; dfdy = b[4];
            end
            if (n_acc >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (n_acc != 2 || n_res != 2) begin
            failures++;
            $display("FAIL b2b_counts: accepts=%0d results=%0d, want 2 2", n_acc, n_res);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 5) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d cycles, want 5", acc_cyc[1] - acc_cyc[0]);
            end
            checks++;
            if (res[0] !== model(a[0], a[1], a[2], a[3], a[4])) begin
                failures++;
                $display("FAIL b2b_first: got %h, want %h", res[0], model(a[0], a[1], a[2], a[3], a[4]));
            end
            checks++;
            if (res[1] !== model(b[0], b[1], b[2], b[3], b[4])) begin
                failures++;
                $display("FAIL b2b_second: got %h, want %h", res[1], model(b[0], b[1], b[2], b[3], b[4]));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] z, exp_z; int lat; bit to;
        logic [15:0] v [5];
        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < 5; j++) begin
                case ($urandom_range(0, 5))
                    0: v[j] = 16'h8000;
                    1: v[j] = 16'h7FFF;
                    2: v[j] = 16'hFFFF;
                    default: v[j] = 16'($urandom);
                endcase
            end
            exp_z = model(v[0], v[1], v[2], v[3], v[4]);
            do_op(v[0], v[1], v[2], v[3], v[4], int'($urandom_range(0, 3)), z, lat, to);
            checks++;
            if (to || lat !== 3 || z !== exp_z) begin
                failures++;
                $display("FAIL random[%0d]: got %h lat=%0d timeout=%0d, want %h lat=3", n, z, lat, to, exp_z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_term();
        test_neg_cross();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
